// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared core constants: response FSM state encoding for the memory arbiter,
// the default starvation limit, and the ALU-op / opcode constants used by the
// rest of the core. No ports; import with memory_arbiter_pkg::*.
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    // Number of consecutive lost contests after which fetch is forced through.
    localparam int STARVE_MAX_DEFAULT = 3;

    // Response FSM: which port (if any) owns the read data returning this cycle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IM_RD = 2'd1,
        S_DM_RD = 2'd2
    } resp_state_t;

    // ALU operation select driven by the decoder.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Major opcodes (instruction bits [6:0]).
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Arbitrates a single-port synchronous SRAM between instruction fetch (IM)
// and data memory (DM). Data wins by default; after STARVE_MAX consecutive
// contested losses, fetch is granted once. Grants and the SRAM command are
// combinational; read data returns one cycle after the grant and is steered
// to the port that issued it by a small response FSM.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   im_req, im_addr            fetch read request / word address
//   im_gnt, im_rvalid, im_rdata fetch accept, response valid, response data
//   dm_req, dm_addr, dm_we,
//   dm_be, dm_wdata            data request (pre-qualified), address, store
//   dm_gnt, dm_rvalid, dm_rdata data accept, load valid, load data
//   flush                      pipeline redirect, kills stale fetch response
//   mem_en, mem_we, mem_be,
//   mem_addr, mem_wdata        SRAM command
//   mem_rdata                  SRAM read data (one cycle after read command)
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              im_req,
    input  logic [ADDR_W-1:0] im_addr,
    output logic              im_gnt,
    output logic              im_rvalid,
    output logic [31:0]       im_rdata,

    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,

    input  logic              flush,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    resp_state_t      state;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_full;

    // ---------------------------------------------------------------------
    // Grant: DM first, except when fetch has already lost STARVE_MAX times
    // in a row and is still asking. Because im_gnt is derived from dm_gnt,
    // the two can never be high together and an idle port is never granted.
    // ---------------------------------------------------------------------
    assign starve_full = (starve_cnt == CNT_MAX);
    assign dm_gnt      = dm_req & ~(im_req & starve_full);
    assign im_gnt      = im_req & ~dm_gnt;

    // SRAM command mux. Fetch is always a full-word read.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (im_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_be    = 4'b1111;
            mem_addr  = im_addr;
        end
    end

    // ---------------------------------------------------------------------
    // Starvation counter and response FSM. The FSM records which port owns
    // the SRAM output on the following cycle; writes leave it idle so they
    // never produce a response.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
        end else begin
            // With im_req high and no im_gnt, DM must have won a contest.
            if (im_gnt || !im_req) begin
                starve_cnt <= '0;
            end else if (!starve_full) begin
                starve_cnt <= starve_cnt + CNT_ONE;
            end

            if (im_gnt) begin
                state <= S_IM_RD;
            end else if (dm_gnt && !dm_we) begin
                state <= S_DM_RD;
            end else begin
                state <= S_IDLE;
            end
        end
    end

    // A redirect only kills the fetch that is returning now; a fetch granted
    // in the same cycle as the flush moves into S_IM_RD and responds next.
    assign im_rvalid = (state == S_IM_RD) && !flush;
    assign dm_rvalid = (state == S_DM_RD);
    assign im_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int ADDR_W = 30;
    localparam int SMAX   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt, im_rvalid;
    logic [31:0]       im_rdata;
    logic              dm_req, dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic              dm_gnt, dm_rvalid;
    logic [31:0]       dm_rdata;
    logic              flush;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    memory_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
        .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 16)      return 32'hDEADBEEF;
        else if (i == 32) return 32'h11223344;
        else              return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // SRAM environment: driven only by the DUT's command outputs.
    logic [31:0] sram [256];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] <= init_word(i);
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[7:0]];
            end
        end
    end

    int rst_events = 0;
    always @(posedge reset) rst_events++;

    // Reference model: arbitration rules, one outstanding response, and a
    // private copy of memory updated from the writes the model expects.
    initial begin : cmp
        logic [31:0] ref_mem [256];
        int          m_starve, m_pend, seen_rst;
        logic [7:0]  m_addr;
        logic        e_im_g, e_dm_g, e_im_rv, e_dm_rv, both;
        logic [3:0]  e_be;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        m_starve = 0; m_pend = 0; seen_rst = 0; m_addr = '0;
        forever begin
            @(negedge clk);
            if (reset || rst_events != seen_rst) begin
                m_starve = 0;
                m_pend   = 0;
                seen_rst = rst_events;
            end
            e_im_rv = (m_pend == 1) && !flush;
            e_dm_rv = (m_pend == 2);
            both    = im_req && dm_req;
            e_im_g  = 1'b0;
            e_dm_g  = 1'b0;
            if (both && m_starve == SMAX) e_im_g = 1'b1;
            else if (dm_req)              e_dm_g = 1'b1;
            else if (im_req)              e_im_g = 1'b1;
            e_be = e_dm_g ? dm_be : (e_im_g ? 4'hF : 4'h0);

            chk("cmp_im_gnt",    32'(im_gnt),    32'(e_im_g));
            chk("cmp_dm_gnt",    32'(dm_gnt),    32'(e_dm_g));
            chk("cmp_mem_en",    32'(mem_en),    32'(e_im_g | e_dm_g));
            chk("cmp_mem_we",    32'(mem_we),    32'(e_dm_g & dm_we));
            chk("cmp_mem_be",    32'(mem_be),    32'(e_be));
            chk("cmp_im_rvalid", 32'(im_rvalid), 32'(e_im_rv));
            chk("cmp_dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
            if (e_im_g) chk("cmp_mem_addr_im", 32'(mem_addr), 32'(im_addr));
            if (e_dm_g) chk("cmp_mem_addr_dm", 32'(mem_addr), 32'(dm_addr));
            if (e_dm_g && dm_we) chk("cmp_mem_wdata", mem_wdata, dm_wdata);
            if (e_im_rv) chk("cmp_im_rdata", im_rdata, ref_mem[m_addr]);
            if (e_dm_rv) chk("cmp_dm_rdata", dm_rdata, ref_mem[m_addr]);

            if (!reset) begin
                if (e_im_g || !im_req)            m_starve = 0;
                else if (both && m_starve < SMAX) m_starve++;
                if (e_im_g) begin
                    m_pend = 1; m_addr = im_addr[7:0];
                end else if (e_dm_g && !dm_we) begin
                    m_pend = 2; m_addr = dm_addr[7:0];
                end else begin
                    m_pend = 0;
                end
                if (e_dm_g && dm_we)
                    for (int b = 0; b < 4; b++)
                        if (dm_be[b]) ref_mem[dm_addr[7:0]][8*b +: 8] = dm_wdata[8*b +: 8];
            end
        end
    end

    // Apply one cycle of inputs just after the rising edge; returns at +2.
    task automatic step(input logic ir, input logic [ADDR_W-1:0] ia,
                        input logic dr, input logic dw, input logic [3:0] db,
                        input logic [ADDR_W-1:0] da, input logic [31:0] dd,
                        input logic fl);
        @(posedge clk);
        #1;
        im_req = ir; im_addr = ia;
        dm_req = dr; dm_we = dw; dm_be = db; dm_addr = da; dm_wdata = dd;
        flush = fl;
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
    endtask

    initial begin : main
        logic [1:0] exp_pat [6];
        logic [1:0] got;
        reset = 1'b1;
        im_req = 0; im_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0;
        dm_addr = '0; dm_wdata = '0; flush = 0;

        // Grant stays combinational during reset; no responses.
        step(1'b1, 30'h10, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
        chk("rst_im_gnt",    32'(im_gnt),      32'd1);
        chk("rst_im_rvalid", 32'(im_rvalid),   32'd0);
        chk("rst_dm_rvalid", 32'(dm_rvalid),   32'd0);
        chk("rst_state",     32'(dut.state),   32'(S_IDLE));
        chk("rst_starve",    32'(dut.starve_cnt), 32'd0);
        idle();
        reset = 1'b0;
        idle();

        // Single fetch, one-cycle latency.
        step(1'b1, 30'h10, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
        chk("fetch_gnt",      32'(im_gnt),   32'd1);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h10);
        chk("fetch_mem_be",   32'(mem_be),   32'hF);
        idle();
        chk("fetch_rvalid",   32'(im_rvalid), 32'd1);
        chk("fetch_rdata",    im_rdata,       32'hDEADBEEF);

        // Contention for six cycles: DM x3, IM, DM x2.
        exp_pat = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        for (int c = 0; c < 6; c++) begin
            step(1'b1, ADDR_W'(32'h60 + c), 1'b1, 1'b0, 4'hF, ADDR_W'(32'h70 + c), 32'h0, 1'b0);
            got = {im_gnt, dm_gnt};
            chk($sformatf("starve_c%0d", c), 32'(got), 32'(exp_pat[c]));
        end
        idle();
        chk("starve_last_rvalid", 32'(dm_rvalid), 32'd1);
        chk("starve_last_rdata",  dm_rdata,       32'hC0DE0075);

        // Partial write, then read it back.
        step(1'b0, '0, 1'b1, 1'b1, 4'b0100, 30'h20, 32'h00AB0000, 1'b0);
        chk("wr_gnt",    32'(dm_gnt),  32'd1);
        chk("wr_mem_we", 32'(mem_we),  32'd1);
        chk("wr_mem_be", 32'(mem_be),  32'h4);
        chk("wr_wdata",  mem_wdata,    32'h00AB0000);
        step(1'b0, '0, 1'b1, 1'b0, 4'hF, 30'h20, 32'h0, 1'b0);
        chk("wr_no_rvalid", 32'(dm_rvalid), 32'd0);
        idle();
        chk("wr_rb_rvalid", 32'(dm_rvalid), 32'd1);
        chk("wr_rb_rdata",  dm_rdata,       32'h11AB3344);

        // Flush kills the stale fetch but not the redirect target.
        step(1'b1, 30'h30, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b0);
        step(1'b1, 30'h10, 1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1);
        chk("flush_new_gnt", 32'(im_gnt),    32'd1);
        chk("flush_kill",    32'(im_rvalid), 32'd0);
        idle();
        chk("flush_tgt_rvalid", 32'(im_rvalid), 32'd1);
        chk("flush_tgt_rdata",  im_rdata,       32'hDEADBEEF);

        // Reset mid-cycle with a DM read outstanding and starve_cnt at 2.
        idle();
        step(1'b1, 30'h51, 1'b1, 1'b0, 4'hF, 30'h50, 32'h0, 1'b0);
        step(1'b1, 30'h53, 1'b1, 1'b0, 4'hF, 30'h52, 32'h0, 1'b0);
        idle();
        chk("rstmid_pre_rvalid", 32'(dm_rvalid),      32'd1);
        chk("rstmid_pre_starve", 32'(dut.starve_cnt), 32'd2);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_drop", 32'(dm_rvalid), 32'd0);
        reset = 1'b0;
        #2;
        chk("rstmid_state",  32'(dut.state),      32'(S_IDLE));
        chk("rstmid_starve", 32'(dut.starve_cnt), 32'd0);
        idle();
        chk("rstmid_no_resp", 32'(dm_rvalid), 32'd0);

        // Read / write / read back-to-back.
        step(1'b0, '0, 1'b1, 1'b0, 4'hF, 30'h40, 32'h0, 1'b0);
        chk("alt_c0_rvalid", 32'(dm_rvalid), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1, 4'hF, 30'h41, 32'h12345678, 1'b0);
        chk("alt_c1_rvalid", 32'(dm_rvalid), 32'd1);
        chk("alt_c1_rdata",  dm_rdata,       32'hC0DE0040);
        step(1'b0, '0, 1'b1, 1'b0, 4'hF, 30'h42, 32'h0, 1'b0);
        chk("alt_c2_rvalid", 32'(dm_rvalid), 32'd0);
        idle();
        chk("alt_c3_rvalid", 32'(dm_rvalid), 32'd1);
        chk("alt_c3_rdata",  dm_rdata,       32'hC0DE0042);

        idle();
        idle();
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 30, giving the width of the word address.
REQ-002 The module SHALL have parameter STARVE_MAX, default 3, giving the number of consecutive lost contests after which fetch wins.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port im_req, input, 1 bit: instruction-fetch read request.
REQ-006 Port im_addr, input, ADDR_W bits: fetch word address.
REQ-007 Port im_gnt, output, 1 bit: fetch request accepted this cycle.
REQ-008 Port im_rvalid, output, 1 bit: im_rdata is valid this cycle.
REQ-009 Port im_rdata, output, 32 bits: fetched instruction word.
REQ-010 Port dm_req, input, 1 bit: data-memory request, already qualified by the decoder (no misaligned or illegal access).
REQ-011 Port dm_addr, input, ADDR_W bits: data word address.
REQ-012 Port dm_we, input, 1 bit: data write request.
REQ-013 Port dm_be, input, 4 bits: data byte enables.
REQ-014 Port dm_wdata, input, 32 bits: store data.
REQ-015 Port dm_gnt, output, 1 bit: data request accepted this cycle.
REQ-016 Port dm_rvalid, output, 1 bit: dm_rdata is valid this cycle.
REQ-017 Port dm_rdata, output, 32 bits: load data word.
REQ-018 Port flush, input, 1 bit: pipeline redirect; discards stale fetch data.
REQ-019 Ports mem_en, mem_we, mem_be[3:0], mem_addr[ADDR_W-1:0], mem_wdata[31:0], outputs: the single-port synchronous SRAM command.
REQ-020 Port mem_rdata, input, 32 bits: SRAM read data, valid one cycle after a read command.

Function
REQ-021 Grant SHALL be combinational: at most one of im_gnt/dm_gnt is high per cycle; a grant is given only to an asserted request.
REQ-022 Default priority SHALL be DM over IM when both requests are high.
REQ-023 The starvation counter starve_cnt (0..STARVE_MAX) SHALL increment, saturating, on each cycle where im_req and dm_req are both high and DM is granted.
REQ-024 starve_cnt SHALL clear on any cycle where im_gnt is high or im_req is low.
REQ-025 When starve_cnt == STARVE_MAX and both requests are high, IM SHALL be granted and DM SHALL wait.
REQ-026 mem_* SHALL be driven combinationally from the granted port; IM grant SHALL drive mem_we=0 and mem_be=4'b1111; DM grant SHALL pass dm_we, dm_be and dm_wdata through.
REQ-027 mem_en SHALL be high only in a grant cycle; with no grant, mem_we=0 and mem_be=0.
REQ-028 The response FSM SHALL have states S_IDLE, S_IM_RD and S_DM_RD, with the next state set every cycle.
REQ-029 IM grant SHALL move the FSM to S_IM_RD; DM read grant (dm_we=0) to S_DM_RD; DM write grant or no grant to S_IDLE.
REQ-030 Read latency SHALL be exactly 1 cycle: im_rvalid = (state==S_IM_RD) && !flush; dm_rvalid = (state==S_DM_RD).
REQ-031 im_rdata and dm_rdata SHALL be mem_rdata passed through; they are meaningful only while the matching rvalid is high.
REQ-032 Writes SHALL complete at the grant edge and produce no rvalid.
REQ-033 Flush in cycle N SHALL suppress only the response to a fetch granted in cycle N-1; a fetch granted in cycle N (the redirect target) SHALL respond normally in N+1.
REQ-034 Back-to-back grants SHALL be allowed every cycle, giving full throughput with one outstanding read at a time.

Reset
REQ-035 Reset SHALL force state=S_IDLE, starve_cnt=0, im_rvalid=0 and dm_rvalid=0 immediately, without waiting for a clock edge.
REQ-036 Reset asserted while a read is outstanding SHALL drop that response, with no rvalid after reset release.
REQ-037 The grant and mem_* outputs SHALL remain combinational functions of the requests and starve_cnt during reset.

Structure
REQ-038 FSM state encodings and the STARVE_MAX default SHALL live in a shared core header/package alongside the ALU-op and opcode constants.
REQ-039 The module SHALL be a single flat module with no sub-modules.

Verification
REQ-040 The bench SHALL cover: im_req alone, im_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> im_gnt in cycle 0, im_rvalid with im_rdata=0xDEADBEEF in cycle 1.
REQ-041 The bench SHALL cover: im_req and dm_req (read) held high for 6 cycles, STARVE_MAX=3 -> dm_gnt in cycles 0-2, im_gnt in cycle 3, dm_gnt in cycles 4-5.
REQ-042 The bench SHALL cover: DM write, dm_be=4'b0100, dm_wdata=0x00AB0000 -> mem_we=1 and mem_be=4'b0100 in the grant cycle, no dm_rvalid afterwards.
REQ-043 The bench SHALL cover: fetch granted in cycle 0, flush in cycle 1 together with a new fetch grant -> im_rvalid=0 in cycle 1, im_rvalid=1 in cycle 2.
REQ-044 The bench SHALL cover: DM read granted, then reset pulsed mid-cycle before the next edge -> dm_rvalid falls immediately, and state=S_IDLE and starve_cnt=0 after release.
REQ-045 The bench SHALL cover: alternating DM read/write/read in consecutive cycles -> dm_rvalid pattern 0,1,0,1 with each dm_rdata matching its own address.
